// File: rtl/perf_log_ctrl_pkg.sv
// Shared types and defaults for the performance/log controller.
package perf_pkg;

   localparam int DEF_EVENT_NUM = 16;
   localparam int DEF_CNT_WIDTH = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SNAP = 2'd1,
      DUMP = 2'd2
   } PerfState;

   typedef struct packed {
      logic [31:0] id;
      logic [63:0] value;
      logic        last;
   } PerfDumpBeat;

   // Index width never collapses to zero for a single-event build.
   function automatic int id_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/perf_log_ctrl_event_counter.sv
// One saturating event counter with a sticky overflow flag.
module perf_event_counter #(
   parameter int CNT_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_inc,
   output logic [CNT_WIDTH-1:0] o_value,
   output logic                 o_overflow
);

   logic [CNT_WIDTH-1:0] r_value;
   logic                 r_ovf;

   // An increment arriving at all-ones is dropped and remembered as overflow.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_value <= '0;
         r_ovf   <= 1'b0;
      end else if (i_inc) begin
         if (&r_value) r_ovf <= 1'b1;
         else          r_value <= r_value + CNT_WIDTH'(1);
      end
   end

   assign o_value    = r_value;
   assign o_overflow = r_ovf;

endmodule

// File: rtl/perf_log_ctrl.sv
// Cycle counter, log window, event counters and serialised snapshot dump port.
module perf_log_ctrl
   import perf_pkg::*;
#(
   parameter  int EVENT_NUM    = DEF_EVENT_NUM,
   parameter  int CNT_WIDTH    = DEF_CNT_WIDTH,
   parameter  int PERIOD_WIDTH = 32,
   localparam int ID_W         = id_width(EVENT_NUM)
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    cfg_en,
   input  logic [63:0]             cfg_start_cycle,
   input  logic [PERIOD_WIDTH-1:0] cfg_period,
   input  logic                    dump_req,
   input  logic [EVENT_NUM-1:0]    event_inc,
   output logic [63:0]             cycle_cnt,
   output logic                    log_valid,
   output logic                    dump_valid,
   input  logic                    dump_ready,
   output logic [ID_W-1:0]         dump_id,
   output logic [CNT_WIDTH-1:0]    dump_value,
   output logic                    dump_last,
   output logic [EVENT_NUM-1:0]    overflow,
   output logic                    missed_dump,
   output logic                    busy
);

   localparam logic [ID_W-1:0] LAST_IDX = ID_W'(EVENT_NUM - 1);

   logic [63:0]             r_cycle;
   logic                    r_log_valid;
   logic [PERIOD_WIDTH-1:0] r_timer;
   PerfState                r_state;
   logic [ID_W-1:0]         r_idx;
   logic                    r_missed;
   logic [CNT_WIDTH-1:0]    r_snap [EVENT_NUM];

   logic [CNT_WIDTH-1:0]    w_cnt [EVENT_NUM];
   logic [EVENT_NUM-1:0]    w_ovf;
   logic                    w_timer_act;
   logic                    w_ptrig;
   logic                    w_trig;
   logic                    w_is_last;

   for (genvar g = 0; g < EVENT_NUM; g++) begin : g_cnt
      perf_event_counter #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_cnt (
         .clk        (clk),
         .rst        (rst),
         .i_inc      (event_inc[g]),
         .o_value    (w_cnt[g]),
         .o_overflow (w_ovf[g])
      );
   end

   assign w_timer_act = r_log_valid && (cfg_period != '0);
   assign w_ptrig     = w_timer_act && (r_timer == cfg_period - PERIOD_WIDTH'(1));
   assign w_trig      = w_ptrig || (dump_req && r_log_valid);
   assign w_is_last   = (r_idx == LAST_IDX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cycle     <= '0;
         r_log_valid <= 1'b0;
         r_timer     <= '0;
      end else begin
         r_cycle     <= r_cycle + 64'd1;
         r_log_valid <= cfg_en && (r_cycle >= cfg_start_cycle);
         if (!w_timer_act) r_timer <= '0;
         else if (w_ptrig) r_timer <= '0;
         else              r_timer <= r_timer + PERIOD_WIDTH'(1);
      end
   end

   // Any trigger seen outside IDLE, including the cycle the last beat leaves, is lost.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state  <= IDLE;
         r_idx    <= '0;
         r_missed <= 1'b0;
      end else begin
         if (w_trig && (r_state != IDLE)) r_missed <= 1'b1;
         case (r_state)
            IDLE: if (w_trig) r_state <= SNAP;
            SNAP: begin
               r_idx   <= '0;
               r_state <= DUMP;
            end
            DUMP: if (dump_ready) begin
               if (w_is_last) r_state <= IDLE;
               else           r_idx   <= r_idx + ID_W'(1);
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Snapshot takes the pre-increment live values; data path needs no reset.
   always_ff @(posedge clk) begin
      if (r_state == SNAP) begin
         for (int i = 0; i < EVENT_NUM; i++) r_snap[i] <= w_cnt[i];
      end
   end

   assign cycle_cnt   = r_cycle;
   assign log_valid   = r_log_valid;
   assign dump_valid  = (r_state == DUMP);
   assign dump_id     = (r_state == DUMP) ? r_idx : '0;
   assign dump_value  = (r_state == DUMP) ? r_snap[r_idx] : '0;
   assign dump_last   = (r_state == DUMP) && w_is_last;
   assign overflow    = w_ovf;
   assign missed_dump = r_missed;
   assign busy        = (r_state != IDLE);

endmodule

// File: tb/tb_perf_log_ctrl.sv
// Randomised and directed bench for perf_log_ctrl against a queue-based reference model.
module tb_perf_log_ctrl;
   import perf_pkg::*;

   localparam int EN   = 16;
   localparam int CW   = 4;
   localparam int PW   = 32;
   localparam int IDW  = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_en = 1'b0;
   logic [63:0]   cfg_start_cycle = '0;
   logic [PW-1:0] cfg_period = '0;
   logic          dump_req = 1'b0;
   logic [EN-1:0] event_inc = '0;
   logic          dump_ready = 1'b0;
   logic [63:0]   cycle_cnt;
   logic          log_valid;
   logic          dump_valid;
   logic [IDW-1:0] dump_id;
   logic [CW-1:0] dump_value;
   logic          dump_last;
   logic [EN-1:0] overflow;
   logic          missed_dump;
   logic          busy;

   perf_log_ctrl #(
      .EVENT_NUM    (EN),
      .CNT_WIDTH    (CW),
      .PERIOD_WIDTH (PW)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .cfg_en          (cfg_en),
      .cfg_start_cycle (cfg_start_cycle),
      .cfg_period      (cfg_period),
      .dump_req        (dump_req),
      .event_inc       (event_inc),
      .cycle_cnt       (cycle_cnt),
      .log_valid       (log_valid),
      .dump_valid      (dump_valid),
      .dump_ready      (dump_ready),
      .dump_id         (dump_id),
      .dump_value      (dump_value),
      .dump_last       (dump_last),
      .overflow        (overflow),
      .missed_dump     (missed_dump),
      .busy            (busy)
   );

   always #5 clk = ~clk;

   int n_assert = 0;
   int n_fail   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: counts per rule, a dump is a queue of pending beats.
   longint unsigned m_cycle;
   bit              m_lv;
   int unsigned     m_timer;
   int              m_cnt [EN];
   bit              m_ovf [EN];
   bit              m_missed;
   bit              m_snap;
   PerfDumpBeat     m_q[$];
   bit              m_act, m_ptrig, m_trig, m_busy_pre;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cycle = 0; m_lv = 0; m_timer = 0; m_missed = 0; m_snap = 0;
         m_q.delete();
         for (int i = 0; i < EN; i++) begin m_cnt[i] = 0; m_ovf[i] = 0; end
      end else begin
         m_act      = m_lv && (cfg_period != 0);
         m_ptrig    = m_act && (m_timer == cfg_period - 1);
         m_trig     = m_ptrig || (dump_req && m_lv);
         m_busy_pre = m_snap || (m_q.size() != 0);
         if (m_snap) begin
            for (int i = 0; i < EN; i++)
               m_q.push_back('{id: i, value: m_cnt[i], last: (i == EN - 1)});
            m_snap = 0;
         end else if (m_q.size() != 0 && dump_ready) begin
            void'(m_q.pop_front());
         end
         if (m_trig) begin
            if (!m_busy_pre) m_snap = 1;
            else             m_missed = 1;
         end
         m_timer = m_act ? (m_ptrig ? 0 : m_timer + 1) : 0;
         for (int i = 0; i < EN; i++)
            if (event_inc[i]) begin
               if (m_cnt[i] == CMAX) m_ovf[i] = 1;
               else                  m_cnt[i]++;
            end
         m_lv = cfg_en && (m_cycle >= cfg_start_cycle);
         m_cycle++;
      end
   end

   PerfDumpBeat acc_q[$];
   logic [EN-1:0] exp_ovf;

   always @(negedge clk) begin
      if (rst) begin
         chk("rst_cycle_cnt", cycle_cnt, 0);
         chk("rst_outputs", {log_valid, dump_valid, dump_id, dump_value, dump_last,
                             overflow, missed_dump, busy}, 0);
      end else begin
         for (int i = 0; i < EN; i++) exp_ovf[i] = m_ovf[i];
         chk("cycle_cnt", cycle_cnt, m_cycle);
         chk("log_valid", log_valid, m_lv);
         chk("dump_valid", dump_valid, m_q.size() != 0);
         chk("busy", busy, m_snap || (m_q.size() != 0));
         chk("missed_dump", missed_dump, m_missed);
         chk("overflow", overflow, exp_ovf);
         if (m_q.size() != 0) begin
            chk("dump_id", dump_id, m_q[0].id);
            chk("dump_value", dump_value, m_q[0].value);
            chk("dump_last", dump_last, m_q[0].last);
         end
         if (dump_valid && dump_ready)
            acc_q.push_back('{id: dump_id, value: dump_value, last: dump_last});
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; dump_req = 1'b0; event_inc = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic wait_busy(input string nm, input int lim);
      int n = 0;
      while (!busy && n < lim) begin tick(); n++; end
      if (!busy) chk(nm, busy, 1);
   endtask

   task automatic wait_idle(input string nm, input int lim);
      int n = 0;
      while (busy && n < lim) begin
         if (nm == "toggle_idle") dump_ready = ~dump_ready;
         tick(); n++;
      end
      if (busy) chk(nm, busy, 0);
   endtask

   task automatic manual_dump(input string nm);
      acc_q.delete();
      dump_req = 1'b1; tick(); dump_req = 1'b0;
      wait_idle(nm, 200);
   endtask

   int n_last, last_id;
   bit order_ok;
   int id_sum;

   initial begin
      // Idle after reset
      repeat (3) tick();
      rst = 1'b0;
      repeat (100) tick();
      chk("idle_cycle_cnt", cycle_cnt, 100);
      chk("idle_log_valid", log_valid, 0);

      // Periodic dump, ready high, seven events on id 3
      cfg_en = 1'b1; cfg_start_cycle = 64'd10; cfg_period = 50; dump_ready = 1'b1;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         event_inc = EN'(1 << 3); tick(); event_inc = '0; tick();
      end
      acc_q.delete();
      wait_busy("periodic_trigger", 200);
      tick();
      chk("first_beat_cycle", cycle_cnt, 62);
      chk("first_beat_valid", dump_valid, 1);
      wait_idle("periodic_idle", 100);
      chk("periodic_n_beats", acc_q.size(), 16);
      chk("periodic_beat3", acc_q[3].value, 7);
      n_last = 0; last_id = -1;
      foreach (acc_q[i]) if (acc_q[i].last) begin n_last++; last_id = int'(acc_q[i].id); end
      chk("periodic_n_last", n_last, 1);
      chk("periodic_last_id", last_id, 15);

      // Same with ready toggling
      do_reset();
      for (int k = 0; k < 7; k++) begin
         event_inc = EN'(1 << 3); tick(); event_inc = '0; tick();
      end
      acc_q.delete();
      wait_busy("toggle_trigger", 200);
      wait_idle("toggle_idle", 200);
      dump_ready = 1'b1;
      chk("toggle_n_beats", acc_q.size(), 16);
      order_ok = 1;
      foreach (acc_q[i]) if (acc_q[i].id != i) order_ok = 0;
      chk("toggle_order", order_ok, 1);
      chk("toggle_beat3", acc_q[3].value, 7);

      // Saturation
      cfg_start_cycle = '0; cfg_period = '0;
      do_reset();
      event_inc = EN'(1); repeat (20) tick(); event_inc = '0;
      chk("sat_overflow0", overflow[0], 1);
      manual_dump("sat_idle");
      chk("sat_value0", acc_q[0].value, 15);
      repeat (5) tick();
      chk("sat_overflow_sticky", overflow[0], 1);

      // Stalled sink with periodic triggers
      cfg_period = 4; dump_ready = 1'b0;
      do_reset();
      repeat (30) tick();
      chk("stall_busy", busy, 1);
      chk("stall_valid", dump_valid, 1);
      chk("stall_id", dump_id, 0);
      chk("stall_missed", missed_dump, 1);

      // Increment landing on the snapshot cycle
      cfg_period = '0; dump_ready = 1'b1;
      do_reset();
      repeat (3) tick();
      for (int k = 0; k < 5; k++) begin
         event_inc = EN'(1 << 1); tick(); event_inc = '0; tick();
      end
      acc_q.delete();
      dump_req = 1'b1; tick(); dump_req = 1'b0;
      chk("snap_busy", busy, 1);
      event_inc = EN'(1 << 1); tick(); event_inc = '0;
      wait_idle("snap_idle", 100);
      chk("snap_value_pre", acc_q[1].value, 5);
      manual_dump("snap2_idle");
      chk("snap_value_next", acc_q[1].value, 6);

      // Reset aborting a dump
      dump_req = 1'b1; tick(); dump_req = 1'b0;
      repeat (4) tick();
      rst = 1'b1; #1;
      chk("rst_abort_valid", dump_valid, 0);
      tick(); tick();
      rst = 1'b0;
      repeat (3) tick();
      manual_dump("post_rst_idle");
      id_sum = 0;
      foreach (acc_q[i]) id_sum += int'(acc_q[i].value);
      chk("post_rst_counters_zero", id_sum, 0);
      chk("post_rst_n_beats", acc_q.size(), 16);

      // Randomised traffic against the model
      cfg_en = 1'b1; cfg_start_cycle = 64'($urandom_range(0, 20)); cfg_period = 7;
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if (c % 250 == 249) begin
            cfg_period = PW'($urandom_range(0, 30));
            cfg_en     = ($urandom % 5) != 0;
         end
         event_inc  = EN'($urandom & $urandom & $urandom);
         dump_req   = ($urandom % 20) == 0;
         dump_ready = ($urandom % 4) != 0;
         tick();
      end
      dump_req = 1'b0; event_inc = '0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, n_fail %0d", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
